// File: rtl/interp_pkg.sv
// Shared types, default sizes and interpolation arithmetic for interpolator_1.
package interp_pkg;

  localparam int unsigned INTERP_WORD_LENGTH = 8;
  localparam int unsigned INTERP_LOG2_FACTOR = 2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } interp_state_t;

  // Operands arrive sign-extended to 32 bits; the arithmetic shift floors toward -inf.
  function automatic logic signed [31:0] interp_point(
    input logic signed [31:0] prev,
    input logic signed [31:0] curr,
    input logic        [31:0] ph,
    input int unsigned        log2_factor = INTERP_LOG2_FACTOR
  );
    logic signed [31:0] prod;
    prod = (curr - prev) * $signed(ph);
    return prev + (prod >>> log2_factor);
  endfunction

endpackage

// File: rtl/interp_phase_ctr.sv
// Phase counter for interpolator_1: counts 0..2^Width-1 while enabled, clears on request.
module interp_phase_ctr #(
  parameter int unsigned Width = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] ph_o,
  output logic             wrap_o
);

  logic [Width-1:0] ph_q, ph_d;

  assign ph_o   = ph_q;
  assign wrap_o = (ph_q == {Width{1'b1}});

  always_comb begin
    ph_d = ph_q;
    if (clr_i) begin
      ph_d = '0;
    end else if (en_i) begin
      ph_d = wrap_o ? '0 : ph_q + Width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_d;
    end
  end

endmodule

// File: rtl/interpolator_1.sv
// L-times upsampler with linear interpolation between successive samples.
// Define INTERP_LINEAR_EN for linear interpolation; otherwise zero-order hold (y = prev).
module interpolator_1
  import interp_pkg::*;
#(
  parameter int unsigned word_length = INTERP_WORD_LENGTH,
  parameter int unsigned log2_factor = INTERP_LOG2_FACTOR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold,
  output logic [word_length-1:0] data_out,
  output logic                   out_valid,
  output logic                   underrun
);

  interp_state_t          state_q, state_d;
  logic [word_length-1:0] prev_q, prev_d;
  logic [word_length-1:0] curr_q, curr_d;
  logic [word_length-1:0] data_out_q, data_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   underrun_q, underrun_d;
  logic [log2_factor-1:0] ph;
  logic                   ph_wrap, ph_en, ph_clr;
  logic                   accept;
  logic [word_length-1:0] y;

  interp_phase_ctr #(
    .Width (log2_factor)
  ) u_phase_ctr (
    .clock  (clock),
    .reset  (reset),
    .en_i   (ph_en),
    .clr_i  (ph_clr),
    .ph_o   (ph),
    .wrap_o (ph_wrap)
  );

  assign in_ready = !hold && ((state_q != RUN) || ph_wrap);
  assign accept   = in_valid && in_ready;

`ifdef INTERP_LINEAR_EN
  assign y = word_length'(interp_point(32'($signed(prev_q)), 32'($signed(curr_q)), 32'(ph),
                                       log2_factor));
`else
  logic unused_ph;
  assign unused_ph = ^ph;
  assign y = prev_q;
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    curr_d      = curr_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    ph_en       = 1'b0;
    ph_clr      = 1'b0;
    if (!hold) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            curr_d  = data_in;
            state_d = PRIMED;
          end
        end
        PRIMED: begin
          if (accept) begin
            prev_d  = curr_q;
            curr_d  = data_in;
            ph_clr  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          ph_en       = 1'b1;
          data_out_d  = y;
          out_valid_d = 1'b1;
          // At wrap, a missing sample repeats curr so the next interval is flat.
          if (ph_wrap) begin
            prev_d = curr_q;
            if (accept) begin
              curr_d = data_in;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      curr_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      curr_q      <= curr_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_interpolator_1.sv
// Directed scoreboard bench for interpolator_1 (word_length 8, L = 4).
module tb_interpolator_1;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       in_valid = 1'b0;
  logic       hold     = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       underrun;

  int         n_cmp   = 0;
  int         n_err   = 0;
  int         n_under = 0;
  bit         refill  = 1'b0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] held    = 8'h00;

  always #5 clock = ~clock;

  interpolator_1 #(
    .word_length (8),
    .log2_factor (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .data_out  (data_out),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      data_in  = src_q[0];
    end else begin
      in_valid = 1'b0;
      data_in  = 8'h00;
    end
  endtask

  // One clock: note the handshake before the edge, consume the sample after it.
  task automatic tick();
    logic acc;
    @(negedge clock);
    acc = in_valid && in_ready && reset;
    @(posedge clock);
    #1;
    if (acc) void'(src_q.pop_front());
    drive_src();
  endtask

  task automatic run_until(input int left, input int budget);
    int cyc = 0;
    while (exp_q.size() > left && cyc < budget) begin
      tick();
      cyc++;
      if (underrun === 1'b1) begin
        n_under++;
        if (refill) begin
          src_q.push_back(8'h40);
          src_q.push_back(8'h40);
          refill = 1'b0;
          drive_src();
        end
      end
      if (out_valid === 1'b1) begin
        held = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(held));
      end
    end
    check("drained", 32'(exp_q.size()), 32'(left));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hold  = 1'b0;
    src_q.delete();
    exp_q.delete();
    drive_src();
    @(posedge clock);
    #3 reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clock);
    #3 reset = 1'b1;

    // Rising ramp then flat
    src_q = '{8'h10, 8'h20, 8'h20};
    drive_src();
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h20, 8'h20, 8'h20};
`else
    exp_q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20};
`endif
    run_until(0, 10);

    // Falling ramp
    do_reset();
    src_q = '{8'h20, 8'h10, 8'h10};
    drive_src();
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h20, 8'h1C, 8'h18, 8'h14, 8'h10};
`else
    exp_q = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h10};
`endif
    run_until(0, 7);

    // Signed extremes, floor rounding
    do_reset();
    src_q = '{8'h7F, 8'h80};
    drive_src();
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h7F, 8'h3F, 8'hFF, 8'hBF};
`else
    exp_q = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
`endif
    run_until(0, 6);

    // Underrun at the first wrap, then refill with 0x40
    do_reset();
    src_q   = '{8'h10, 8'h20};
    drive_src();
    n_under = 0;
    refill  = 1'b1;
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h20, 8'h20, 8'h20,
              8'h20, 8'h28, 8'h30, 8'h38};
`else
    exp_q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20,
              8'h20, 8'h20, 8'h20, 8'h20};
`endif
    run_until(0, 14);
    check("underrun_count", 32'(n_under), 32'd1);
    check("underrun_refill", 32'(refill), 32'h0);

    // Hold for five cycles after the second output
    do_reset();
    src_q = '{8'h10, 8'h20, 8'h20};
    drive_src();
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h20, 8'h20, 8'h20};
`else
    exp_q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20};
`endif
    run_until(6, 4);
    hold = 1'b1;
    #1;
    check("hold_in_ready_now", 32'(in_ready), 32'h0);
    repeat (5) begin
      tick();
      check("hold_data_out", 32'(data_out), 32'(held));
      check("hold_out_valid", 32'(out_valid), 32'h0);
      check("hold_in_ready", 32'(in_ready), 32'h0);
      check("hold_underrun", 32'(underrun), 32'h0);
    end
    hold = 1'b0;
    run_until(0, 6);

    // Asynchronous reset between edges while running
    do_reset();
    src_q = '{8'h10, 8'h20, 8'h20};
    drive_src();
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h10, 8'h14};
`else
    exp_q = '{8'h10, 8'h10};
`endif
    run_until(0, 4);
    #2 reset = 1'b0;
    #1;
    check("arst_data_out", 32'(data_out), 32'h00);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_underrun", 32'(underrun), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    src_q.delete();
    exp_q.delete();
    src_q = '{8'h30, 8'h50};
    drive_src();
    @(posedge clock);
    #3 reset = 1'b1;
    tick();
    check("arst_one_sample", 32'(out_valid), 32'h0);
    tick();
    check("arst_two_samples", 32'(out_valid), 32'h0);
`ifdef INTERP_LINEAR_EN
    exp_q = '{8'h30, 8'h38, 8'h40, 8'h48};
`else
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30};
`endif
    run_until(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
